// File: rtl/counter_port_arbiter.sv
// counter_port_arbiter: shares one up/down counter between NUM_REQ requesters.
// Each cycle at most one increment and one decrement requester is granted,
// round-robin within each class; grants that would push the counter out of
// range are withheld, and a reinit load is sequenced through RUN/REINIT/SETTLE.
module counter_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int AMT_W   = 2,
    parameter int STALL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*AMT_W-1:0] req_amt,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     cfg_reinit,
    input  logic [WIDTH-1:0]         cfg_initial_value,
    output logic                     cfg_busy,
    input  logic [WIDTH-1:0]         value,
    output logic                     cnt_incr_valid,
    output logic [AMT_W-1:0]         cnt_incr,
    output logic                     cnt_decr_valid,
    output logic [AMT_W-1:0]         cnt_decr,
    output logic                     cnt_reinit,
    output logic [WIDTH-1:0]         cnt_initial_value,
    output logic [STALL_W-1:0]       stall_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = WIDTH + AMT_W + 1;
    localparam logic [PTR_W-1:0]        LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic signed [SUM_W-1:0] MAX_VAL  = SUM_W'((1 << WIDTH) - 1);
    localparam logic signed [SUM_W-1:0] ZERO_VAL = SUM_W'(0);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REINIT = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   incr_ptr_q, incr_ptr_d;
    logic [PTR_W-1:0]   decr_ptr_q, decr_ptr_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [WIDTH-1:0]   init_q, init_d;

    logic                    run_s;
    logic                    inc_found_s, dec_found_s;
    logic [PTR_W-1:0]        inc_idx_s, dec_idx_s;
    logic [AMT_W-1:0]        inc_amt_s, dec_amt_s;
    logic signed [SUM_W-1:0] sum_s;
    logic                    inc_grant_s, dec_grant_s, drop_s;

    // First candidate at or after ptr, wrapping cyclically.
    function automatic void find_cand(input  logic [NUM_REQ-1:0] cand,
                                      input  logic [PTR_W-1:0]   ptr,
                                      output logic               found,
                                      output logic [PTR_W-1:0]   idx);
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && cand[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && cand[i] && (i < int'(ptr))) begin
                found = 1'b1;
                idx   = PTR_W'(i);
            end
        end
    endfunction

    // Amount field of requester idx.
    function automatic logic [AMT_W-1:0] amt_of(input logic [NUM_REQ*AMT_W-1:0] amts,
                                                input logic [PTR_W-1:0]         idx);
        amt_of = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == idx) begin
                amt_of = amts[i*AMT_W +: AMT_W];
            end
        end
    endfunction

    // Candidate selection, range check and grant decision.
    always_comb begin
        run_s = rst && (state_q == ST_RUN);
        find_cand(req_valid & ~req_op, incr_ptr_q, inc_found_s, inc_idx_s);
        find_cand(req_valid & req_op, decr_ptr_q, dec_found_s, dec_idx_s);
        inc_amt_s = inc_found_s ? amt_of(req_amt, inc_idx_s) : '0;
        dec_amt_s = dec_found_s ? amt_of(req_amt, dec_idx_s) : '0;
        sum_s = $signed({{(AMT_W+1){1'b0}}, value})
              + $signed({{(WIDTH+1){1'b0}}, inc_amt_s})
              - $signed({{(WIDTH+1){1'b0}}, dec_amt_s});
        // Only one bound can be violated at a time, so dropping the
        // offending side always leaves the other grant in range.
        inc_grant_s = run_s && inc_found_s && !(sum_s > MAX_VAL);
        dec_grant_s = run_s && dec_found_s && !(sum_s < ZERO_VAL);
        drop_s = run_s && ((inc_found_s && !inc_grant_s) || (dec_found_s && !dec_grant_s));
    end

    // Drive grant and counter-control outputs; all quiet while in reset.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (inc_grant_s && (inc_idx_s == PTR_W'(i))) ||
                           (dec_grant_s && (dec_idx_s == PTR_W'(i)));
        end
        cnt_incr_valid    = inc_grant_s;
        cnt_incr          = inc_grant_s ? inc_amt_s : '0;
        cnt_decr_valid    = dec_grant_s;
        cnt_decr          = dec_grant_s ? dec_amt_s : '0;
        cnt_reinit        = rst && (state_q == ST_REINIT);
        cfg_busy          = rst && (state_q != ST_RUN);
        cnt_initial_value = rst ? init_q : '0;
        stall_cnt         = stall_q;
    end

    // Next-state for the FSM, pointers, stall counter and captured value.
    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        case (state_q)
            ST_RUN: begin
                if (cfg_reinit) begin
                    state_d = ST_REINIT;
                    init_d  = cfg_initial_value;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REINIT: state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        if (inc_grant_s) begin
            incr_ptr_d = (inc_idx_s == LAST_IDX) ? '0 : inc_idx_s + PTR_W'(1);
        end else begin
            incr_ptr_d = incr_ptr_q;
        end

        if (dec_grant_s) begin
            decr_ptr_d = (dec_idx_s == LAST_IDX) ? '0 : dec_idx_s + PTR_W'(1);
        end else begin
            decr_ptr_d = decr_ptr_q;
        end

        if (drop_s && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            incr_ptr_q <= '0;
            decr_ptr_q <= '0;
            stall_q    <= '0;
            init_q     <= '0;
        end else begin
            state_q    <= state_d;
            incr_ptr_q <= incr_ptr_d;
            decr_ptr_q <= decr_ptr_d;
            stall_q    <= stall_d;
            init_q     <= init_d;
        end
    end

endmodule

// File: tb/tb_counter_port_arbiter.sv
// Directed testbench for counter_port_arbiter with a behavioural counter
// closing the value feedback loop.
module tb_counter_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int AMT_W   = 2;
    localparam int STALL_W = 8;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_op;
    logic [NUM_REQ*AMT_W-1:0] req_amt;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cfg_reinit;
    logic [WIDTH-1:0]         cfg_initial_value;
    logic                     cfg_busy;
    logic [WIDTH-1:0]         value;
    logic                     cnt_incr_valid;
    logic [AMT_W-1:0]         cnt_incr;
    logic                     cnt_decr_valid;
    logic [AMT_W-1:0]         cnt_decr;
    logic                     cnt_reinit;
    logic [WIDTH-1:0]         cnt_initial_value;
    logic [STALL_W-1:0]       stall_cnt;

    logic                     load_req;
    logic [WIDTH-1:0]         load_val;

    int n_checks = 0;
    int n_pass   = 0;

    counter_port_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .AMT_W(AMT_W), .STALL_W(STALL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_amt(req_amt), .req_ready(req_ready),
        .cfg_reinit(cfg_reinit), .cfg_initial_value(cfg_initial_value), .cfg_busy(cfg_busy),
        .value(value),
        .cnt_incr_valid(cnt_incr_valid), .cnt_incr(cnt_incr),
        .cnt_decr_valid(cnt_decr_valid), .cnt_decr(cnt_decr),
        .cnt_reinit(cnt_reinit), .cnt_initial_value(cnt_initial_value),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter: bench preload, reinit load, else add/subtract.
    initial value = '0;
    always @(posedge clk) begin
        if (load_req)
            value <= load_val;
        else if (cnt_reinit)
            value <= cnt_initial_value;
        else
            value <= value + WIDTH'(cnt_incr) - WIDTH'(cnt_decr);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_op    = '0;
        req_amt   = '0;
    endtask

    task automatic set_req(input int i, input logic op, input logic [AMT_W-1:0] amt);
        req_valid[i]           = 1'b1;
        req_op[i]              = op;
        req_amt[i*AMT_W +: AMT_W] = amt;
    endtask

    task automatic load_value(input logic [WIDTH-1:0] v);
        clear_reqs();
        load_req = 1'b1;
        load_val = v;
        next_cycle();
        load_req = 1'b0;
    endtask

    logic [3:0] fair_exp [5];

    initial begin
        rst               = 1'b0;
        cfg_reinit        = 1'b0;
        cfg_initial_value = '0;
        load_req          = 1'b1;
        load_val          = 4'd5;
        clear_reqs();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 2'd1);

        // Reset held two cycles with every requester active.
        next_cycle();
        next_cycle();
        load_req = 1'b0;
        @(negedge clk);
        check_eq("rst_ready",      32'(req_ready),      32'd0);
        check_eq("rst_incr_valid", 32'(cnt_incr_valid), 32'd0);
        check_eq("rst_incr",       32'(cnt_incr),       32'd0);
        check_eq("rst_decr_valid", 32'(cnt_decr_valid), 32'd0);
        check_eq("rst_reinit",     32'(cnt_reinit),     32'd0);
        check_eq("rst_busy",       32'(cfg_busy),       32'd0);
        check_eq("rst_stall",      32'(stall_cnt),      32'd0);
        check_eq("rst_value",      32'(value),          32'd5);
        next_cycle();
        rst = 1'b1;

        // Fairness: four incrementers rotate 0,1,2,3,0.
        fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("fair_ready%0d", k), 32'(req_ready), 32'(fair_exp[k]));
            check_eq($sformatf("fair_incr%0d", k),  32'(cnt_incr),  32'd1);
            next_cycle();
        end
        check_eq("fair_value", 32'(value), 32'd10);

        // Simultaneous increment and decrement (incr_ptr=1, decr_ptr=0).
        load_value(4'd8);
        set_req(1, 1'b0, 2'd3);
        set_req(2, 1'b1, 2'd2);
        @(negedge clk);
        check_eq("sim_ready",      32'(req_ready),      32'd6);
        check_eq("sim_incr_valid", 32'(cnt_incr_valid), 32'd1);
        check_eq("sim_incr",       32'(cnt_incr),       32'd3);
        check_eq("sim_decr_valid", 32'(cnt_decr_valid), 32'd1);
        check_eq("sim_decr",       32'(cnt_decr),       32'd2);
        next_cycle();
        clear_reqs();
        check_eq("sim_value", 32'(value), 32'd9);

        // Overflow: 14+3 dropped, then granted alongside a decrement of 2.
        load_value(4'd14);
        set_req(0, 1'b0, 2'd3);
        @(negedge clk);
        check_eq("ovf_ready",      32'(req_ready),      32'd0);
        check_eq("ovf_incr_valid", 32'(cnt_incr_valid), 32'd0);
        check_eq("ovf_incr",       32'(cnt_incr),       32'd0);
        check_eq("ovf_stall0",     32'(stall_cnt),      32'd0);
        next_cycle();
        check_eq("ovf_stall1", 32'(stall_cnt), 32'd1);
        set_req(3, 1'b1, 2'd2);
        @(negedge clk);
        check_eq("ovf_ready2", 32'(req_ready), 32'd9);
        check_eq("ovf_incr2",  32'(cnt_incr),  32'd3);
        check_eq("ovf_decr2",  32'(cnt_decr),  32'd2);
        next_cycle();
        clear_reqs();
        check_eq("ovf_value", 32'(value), 32'd15);

        // Underflow: 1+0-2 drops the decrement, zero-amount increment granted.
        load_value(4'd1);
        set_req(3, 1'b1, 2'd2);
        set_req(0, 1'b0, 2'd0);
        @(negedge clk);
        check_eq("udf_ready",      32'(req_ready),      32'd1);
        check_eq("udf_incr_valid", 32'(cnt_incr_valid), 32'd1);
        check_eq("udf_incr",       32'(cnt_incr),       32'd0);
        check_eq("udf_decr_valid", 32'(cnt_decr_valid), 32'd0);
        check_eq("udf_decr",       32'(cnt_decr),       32'd0);
        next_cycle();
        clear_reqs();
        check_eq("udf_stall", 32'(stall_cnt), 32'd2);
        check_eq("udf_value", 32'(value),     32'd1);

        // Stall counter saturation: value 15 with a blocked increment.
        load_value(4'd15);
        set_req(0, 1'b0, 2'd1);
        repeat (300) next_cycle();
        @(negedge clk);
        check_eq("sat_ready", 32'(req_ready), 32'd0);
        check_eq("sat_stall", 32'(stall_cnt), 32'd255);
        next_cycle();
        clear_reqs();

        // Reinit during traffic (incr_ptr=1, decr_ptr=0).
        load_value(4'd3);
        set_req(1, 1'b0, 2'd1);
        set_req(2, 1'b1, 2'd1);
        cfg_reinit        = 1'b1;
        cfg_initial_value = 4'd9;
        @(negedge clk);
        check_eq("ri_run_ready", 32'(req_ready),  32'd6);
        check_eq("ri_run_busy",  32'(cfg_busy),   32'd0);
        check_eq("ri_run_load",  32'(cnt_reinit), 32'd0);
        next_cycle();
        cfg_initial_value = 4'd4;
        @(negedge clk);
        check_eq("ri_load",       32'(cnt_reinit),        32'd1);
        check_eq("ri_load_val",   32'(cnt_initial_value), 32'd9);
        check_eq("ri_busy",       32'(cfg_busy),          32'd1);
        check_eq("ri_ready",      32'(req_ready),         32'd0);
        check_eq("ri_incr_valid", 32'(cnt_incr_valid),    32'd0);
        check_eq("ri_decr_valid", 32'(cnt_decr_valid),    32'd0);
        check_eq("ri_value",      32'(value),             32'd3);
        next_cycle();
        @(negedge clk);
        check_eq("st_load",     32'(cnt_reinit),        32'd0);
        check_eq("st_busy",     32'(cfg_busy),          32'd1);
        check_eq("st_ready",    32'(req_ready),         32'd0);
        check_eq("st_load_val", 32'(cnt_initial_value), 32'd9);
        check_eq("st_value",    32'(value),             32'd9);
        next_cycle();
        cfg_reinit = 1'b0;
        @(negedge clk);
        check_eq("rs_ready", 32'(req_ready), 32'd6);
        check_eq("rs_busy",  32'(cfg_busy),  32'd0);
        check_eq("rs_incr",  32'(cnt_incr),  32'd1);
        check_eq("rs_decr",  32'(cnt_decr),  32'd1);
        next_cycle();
        clear_reqs();
        check_eq("rs_value", 32'(value),     32'd9);
        check_eq("rs_stall", 32'(stall_cnt), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
